// File: rtl/wb_sequencer_if.sv
// wb_sequencer_if: bundles the execute-side handshake, the data-memory read
// port and the register-file writeback signals of the writeback sequencer.
//   slave  - seen from the sequencer. It receives instructions and memory
//            responses, and drives the memory request and writeback outputs.
//   master - seen from the surrounding pipeline or the testbench. It drives
//            instructions and memory responses.
// Signals:
//   exValid/exReady              instruction handshake from execute
//   exIsLoad/exRegWrite          instruction attributes
//   exDestReg/exAluResult        destination register, ALU result or load address
//   memReq/memAddr               data-memory read request and address
//   memAck/memReadData           read acknowledge and read data
//   memToReg/wbAluResult/
//   wbReadData                   writeback mux select and its two data inputs
//   regWrite/writeReg            register-file write enable and write address
//   timeoutErr/busy              load-abort pulse and memory-wait indicator
interface wb_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              exValid;
  logic              exReady;
  logic              exIsLoad;
  logic              exRegWrite;
  logic [REG_AW-1:0] exDestReg;
  logic [DATA_W-1:0] exAluResult;
  logic              memReq;
  logic [DATA_W-1:0] memAddr;
  logic              memAck;
  logic [DATA_W-1:0] memReadData;
  logic              memToReg;
  logic [DATA_W-1:0] wbAluResult;
  logic [DATA_W-1:0] wbReadData;
  logic              regWrite;
  logic [REG_AW-1:0] writeReg;
  logic              timeoutErr;
  logic              busy;

  modport slave (
    input  exValid, exIsLoad, exRegWrite, exDestReg, exAluResult,
    input  memAck, memReadData,
    output exReady, memReq, memAddr, memToReg, wbAluResult, wbReadData,
    output regWrite, writeReg, timeoutErr, busy
  );

  modport master (
    output exValid, exIsLoad, exRegWrite, exDestReg, exAluResult,
    output memAck, memReadData,
    input  exReady, memReq, memAddr, memToReg, wbAluResult, wbReadData,
    input  regWrite, writeReg, timeoutErr, busy
  );
endinterface

// File: rtl/wb_sequencer.sv
// wb_sequencer: register-writeback sequencer of the 16-bit CPU.
// It accepts completed instructions from execute. ALU results go straight to
// a one-cycle writeback. A load first issues a data-memory read and waits for
// memAck. If no acknowledge arrives within TIMEOUT cycles, the load is
// aborted and timeoutErr pulses. Every output is a register.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high reset
//   bus   - wb_sequencer_if.slave. It carries the execute handshake, the
//           memory read port and the writeback outputs.
module wb_sequencer #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           reset,
  wb_sequencer_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The wait counter exits at this value, so it can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WB       = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              lat_reg_write_r;
  logic              ex_ready_r;
  logic              mem_req_r;
  logic              busy_r;
  logic [DATA_W-1:0] mem_addr_r;
  logic              mem_to_reg_r;
  logic [DATA_W-1:0] wb_alu_result_r;
  logic [DATA_W-1:0] wb_read_data_r;
  logic              reg_write_r;
  logic [REG_AW-1:0] write_reg_r;
  logic              timeout_err_r;
  logic              accept_s;

  // ex_ready_r is low exactly while a load waits, so it also gates acceptance.
  assign accept_s = bus.exValid & ex_ready_r;

  // FSM: state, wait counter, latched instruction fields and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      wait_cnt_r      <= {CNT_W{1'b0}};
      lat_reg_write_r <= 1'b0;
      ex_ready_r      <= 1'b1;
      mem_req_r       <= 1'b0;
      busy_r          <= 1'b0;
      mem_addr_r      <= {DATA_W{1'b0}};
      mem_to_reg_r    <= 1'b0;
      wb_alu_result_r <= {DATA_W{1'b0}};
      wb_read_data_r  <= {DATA_W{1'b0}};
      reg_write_r     <= 1'b0;
      write_reg_r     <= {REG_AW{1'b0}};
      timeout_err_r   <= 1'b0;
    end else begin
      // Both pulses default low. The branches below raise them for one cycle.
      reg_write_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      case (state_r)
        IDLE, WB: begin
          if (accept_s) begin
            write_reg_r     <= bus.exDestReg;
            lat_reg_write_r <= bus.exRegWrite;
            if (bus.exIsLoad) begin
              mem_addr_r <= bus.exAluResult;
              wait_cnt_r <= {CNT_W{1'b0}};
              mem_req_r  <= 1'b1;
              busy_r     <= 1'b1;
              ex_ready_r <= 1'b0;
              state_r    <= MEM_WAIT;
            end else begin
              wb_alu_result_r <= bus.exAluResult;
              mem_to_reg_r    <= 1'b0;
              reg_write_r     <= bus.exRegWrite;
              state_r         <= WB;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MEM_WAIT: begin
          // An acknowledge in the final wait cycle still beats the timeout.
          if (bus.memAck) begin
            wb_read_data_r <= bus.memReadData;
            mem_to_reg_r   <= 1'b1;
            reg_write_r    <= lat_reg_write_r;
            mem_req_r      <= 1'b0;
            busy_r         <= 1'b0;
            ex_ready_r     <= 1'b1;
            state_r        <= WB;
          end else if (wait_cnt_r == CNT_LAST) begin
            timeout_err_r <= 1'b1;
            mem_req_r     <= 1'b0;
            busy_r        <= 1'b0;
            ex_ready_r    <= 1'b1;
            state_r       <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end
        end
        default: begin
          mem_req_r  <= 1'b0;
          busy_r     <= 1'b0;
          ex_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.exReady     = ex_ready_r;
  assign bus.memReq      = mem_req_r;
  assign bus.memAddr     = mem_addr_r;
  assign bus.memToReg    = mem_to_reg_r;
  assign bus.wbAluResult = wb_alu_result_r;
  assign bus.wbReadData  = wb_read_data_r;
  assign bus.regWrite    = reg_write_r;
  assign bus.writeReg    = write_reg_r;
  assign bus.timeoutErr  = timeout_err_r;
  assign bus.busy        = busy_r;
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: self-checking bench for wb_sequencer.
// A transaction-level model tracks whether a load is in flight and how many
// request cycles it has used. A compare process checks every output on each
// falling edge. Directed scenarios add literal expectations, and a long
// randomized phase follows them.
module tb_wb_sequencer;
  localparam int DATA_W  = 16;
  localparam int REG_AW  = 3;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_sequencer_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  wb_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  logic              m_in_load;
  int                m_waited;
  logic              m_rw;
  logic [DATA_W-1:0] e_mem_addr, e_wb_alu, e_wb_rd;
  logic              e_m2r, e_reg_write, e_terr;
  logic [REG_AW-1:0] e_write_reg;

  // Model: a load occupies the memory port for up to TIMEOUT request cycles.
  always @(posedge clk) begin
    if (reset) begin
      m_in_load   <= 1'b0;
      m_waited    <= 0;
      m_rw        <= 1'b0;
      e_mem_addr  <= '0;
      e_wb_alu    <= '0;
      e_wb_rd     <= '0;
      e_m2r       <= 1'b0;
      e_reg_write <= 1'b0;
      e_terr      <= 1'b0;
      e_write_reg <= '0;
    end else begin
      e_reg_write <= 1'b0;
      e_terr      <= 1'b0;
      if (!m_in_load) begin
        if (bus.exValid) begin
          e_write_reg <= bus.exDestReg;
          m_rw        <= bus.exRegWrite;
          if (bus.exIsLoad) begin
            m_in_load  <= 1'b1;
            m_waited   <= 1;
            e_mem_addr <= bus.exAluResult;
          end else begin
            e_wb_alu    <= bus.exAluResult;
            e_m2r       <= 1'b0;
            e_reg_write <= bus.exRegWrite;
          end
        end
      end else if (bus.memAck) begin
        e_wb_rd     <= bus.memReadData;
        e_m2r       <= 1'b1;
        e_reg_write <= m_rw;
        m_in_load   <= 1'b0;
      end else if (m_waited == TIMEOUT) begin
        e_terr    <= 1'b1;
        m_in_load <= 1'b0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  logic [56:0] act_vec, exp_vec;
  assign act_vec = {bus.exReady, bus.memReq, bus.memAddr, bus.memToReg, bus.wbAluResult,
                    bus.wbReadData, bus.regWrite, bus.writeReg, bus.timeoutErr, bus.busy};
  assign exp_vec = {~m_in_load, m_in_load, e_mem_addr, e_m2r, e_wb_alu,
                    e_wb_rd, e_reg_write, e_write_reg, e_terr, m_in_load};

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: got %h expected %h", $time, act_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic ld, input logic rw, input logic [REG_AW-1:0] dst,
                        input logic [DATA_W-1:0] alu, input logic ack, input logic [DATA_W-1:0] rd);
    bus.exValid     = v;
    bus.exIsLoad    = ld;
    bus.exRegWrite  = rw;
    bus.exDestReg   = dst;
    bus.exAluResult = alu;
    bus.memAck      = ack;
    bus.memReadData = rd;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_req;
    int  n_rw;
    bit  seen;
    int  ack_pct;
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    step();
    step();
    cmp_en = 1'b1;
    chk("reset_regWrite", bus.regWrite, 1'b0);
    chk("reset_memReq", bus.memReq, 1'b0);
    chk("reset_exReady", bus.exReady, 1'b1);
    chk("reset_wbAluResult", bus.wbAluResult, 16'h0000);
    reset = 1'b0;

    // Single ALU op
    set_in(1'b1, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 16'h0000);
    step();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    chk("alu_regWrite", bus.regWrite, 1'b1);
    chk("alu_writeReg", bus.writeReg, 3'd3);
    chk("alu_memToReg", bus.memToReg, 1'b0);
    chk("alu_wbAluResult", bus.wbAluResult, 16'h1234);
    step();
    chk("alu_regWrite_drop", bus.regWrite, 1'b0);

    // Load acknowledged in its 3rd request cycle
    set_in(1'b1, 1'b1, 1'b1, 3'd5, 16'h0040, 1'b0, 16'h0000);
    step();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      chk("load_memReq", bus.memReq, 1'b1);
      chk("load_memAddr", bus.memAddr, 16'h0040);
      chk("load_exReady", bus.exReady, 1'b0);
      if (i == 3) set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'hBEEF);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    chk("load_memReq_drop", bus.memReq, 1'b0);
    chk("load_memToReg", bus.memToReg, 1'b1);
    chk("load_wbReadData", bus.wbReadData, 16'hBEEF);
    chk("load_writeReg", bus.writeReg, 3'd5);
    chk("load_regWrite", bus.regWrite, 1'b1);
    step();

    // Three back-to-back ALU ops
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b0, 1'b1, 3'(k + 1), 16'hA000 + 16'(k), 1'b0, 16'h0000);
      step();
      chk("b2b_regWrite", bus.regWrite, 1'b1);
      chk("b2b_writeReg", bus.writeReg, 32'(k + 1));
      chk("b2b_wbAluResult", bus.wbAluResult, 32'h0000A000 + 32'(k));
    end
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    step();
    chk("b2b_regWrite_drop", bus.regWrite, 1'b0);

    // Load with no acknowledge at all
    set_in(1'b1, 1'b1, 1'b1, 3'd2, 16'h0100, 1'b0, 16'h0000);
    step();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    n_req = 0;
    n_rw  = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.memReq) n_req++;
      if (bus.regWrite) n_rw++;
      if (bus.timeoutErr) begin
        seen = 1'b1;
        chk("timeout_exReady", bus.exReady, 1'b1);
      end else begin
        step();
      end
    end
    chk("timeout_seen", seen, 1'b1);
    chk("timeout_req_cycles", n_req, 15);
    chk("timeout_no_regWrite", n_rw, 0);
    step();
    chk("timeout_pulse_width", bus.timeoutErr, 1'b0);

    // Acknowledge in the final (15th) wait cycle
    set_in(1'b1, 1'b1, 1'b1, 3'd6, 16'h0200, 1'b0, 16'h0000);
    step();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 1; i <= 15; i++) begin
      chk("late_memReq", bus.memReq, 1'b1);
      if (i == 15) set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h5A5A);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    chk("late_regWrite", bus.regWrite, 1'b1);
    chk("late_timeoutErr", bus.timeoutErr, 1'b0);
    chk("late_wbReadData", bus.wbReadData, 16'h5A5A);
    step();
    chk("late_timeoutErr_after", bus.timeoutErr, 1'b0);

    // Reset during the 2nd wait cycle, then a stray acknowledge
    set_in(1'b1, 1'b1, 1'b1, 3'd7, 16'h0300, 1'b0, 16'h0000);
    step();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h7777);
    chk("rst_memReq", bus.memReq, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_memAddr", bus.memAddr, 16'h0000);
    chk("rst_writeReg", bus.writeReg, 3'd0);
    chk("rst_wbReadData", bus.wbReadData, 16'h0000);
    chk("rst_exReady", bus.exReady, 1'b1);
    step();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    chk("rst_ack_ignored_regWrite", bus.regWrite, 1'b0);
    chk("rst_ack_ignored_wbReadData", bus.wbReadData, 16'h0000);
    step();

    // Randomized phase, checked cycle by cycle against the model
    ack_pct = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) ack_pct = (ack_pct == 30) ? 3 : 30;
      reset = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
             REG_AW'($urandom), DATA_W'($urandom),
             $urandom_range(0, 99) < ack_pct, DATA_W'($urandom));
      step();
    end
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
